// File: rtl/cbb_slot_alloc_pkg.sv
// Shared definitions for the slot allocator and neighbouring CBBs.
// Provides the default slot index width, the depth derivation macro and a clog2 helper.

`ifndef CBB_SLOT_ALLOC_PKG_SV
`define CBB_SLOT_ALLOC_PKG_SV

// Number of slots addressed by an index of the given width.
`define CBB_SLOT_DEPTH(w) (1 << (w))

package cbb_slot_alloc_pkg;

  localparam int unsigned SLOT_IDX_W = 3;

  // Ceiling log2, returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/cbb_bin2onehot.sv
// Binary-to-one-hot decoder CBB (shared building block, reused by the slot allocator).

module cbb_bin2onehot #(
  parameter int unsigned BIN_W = 3,
  parameter int unsigned OUT_W = 1 << BIN_W
) (
  input  logic [BIN_W-1:0] bin_in,
  output logic [OUT_W-1:0] onehot_out
);

  // Shift a single set bit into the indexed position.
  always_comb begin
    onehot_out = OUT_W'(1) << bin_in;
  end

endmodule

// File: rtl/cbb_prio_enc.sv
// LSB-first priority encoder: index of the lowest set request bit plus a found flag.
// Index is 0 when no bit is set.

module cbb_prio_enc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbb_slot_alloc.sv
// Slot allocator for the sorter entry buffer: grants the lowest free slot, accepts
// binary-indexed releases, and keeps a registered occupancy map and count.
// Optional build macro CBB_SLOT_ALLOC_CHK_EN adds sticky double-free error reporting.

module cbb_slot_alloc
  import cbb_slot_alloc_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = SLOT_IDX_W,
  localparam int unsigned DEPTH = `CBB_SLOT_DEPTH(IDX_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [IDX_WIDTH-1:0] alloc_idx,
  input  logic                 free_vld,
  input  logic [IDX_WIDTH-1:0] free_idx,
  output logic [DEPTH-1:0]     occ_map,
  output logic [IDX_WIDTH:0]   used_cnt,
  output logic                 full,
  output logic                 empty
`ifdef CBB_SLOT_ALLOC_CHK_EN
  ,
  output logic                 err_dbl_free,
  output logic [IDX_WIDTH-1:0] err_idx
`endif
);

  localparam logic [IDX_WIDTH:0] DepthCnt = (IDX_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]     occ_q, occ_d;
  logic [IDX_WIDTH:0]   cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic [IDX_WIDTH-1:0] enc_idx;
  logic                 enc_found;
  logic [DEPTH-1:0]     free_mask;
  logic [DEPTH-1:0]     alloc_mask;
  logic                 free_ok;

  cbb_prio_enc #(
    .WIDTH (DEPTH),
    .IDX_W (IDX_WIDTH)
  ) u_prio_enc (
    .req   (~occ_q),
    .idx   (enc_idx),
    .found (enc_found)
  );

  cbb_bin2onehot #(
    .BIN_W (IDX_WIDTH),
    .OUT_W (DEPTH)
  ) u_free_dec (
    .bin_in     (free_idx),
    .onehot_out (free_mask)
  );

  // Grant path is combinational off the current map; frees this cycle are not grantable.
  always_comb begin
    alloc_gnt  = alloc_req & ~full_q;
    alloc_idx  = enc_found ? enc_idx : '0;
    alloc_mask = alloc_gnt ? (DEPTH'(1) << alloc_idx) : '0;
    free_ok    = free_vld & (|(occ_q & free_mask));
  end

  // Next map/count; a valid free and a grant never target the same slot.
  always_comb begin
    occ_d   = (occ_q & ~(free_ok ? free_mask : '0)) | alloc_mask;
    cnt_d   = cnt_q + {{IDX_WIDTH{1'b0}}, alloc_gnt} - {{IDX_WIDTH{1'b0}}, free_ok};
    full_d  = (cnt_d == DepthCnt);
    empty_d = (cnt_d == '0);
  end

  // Occupancy state register with synchronous reset overriding any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign occ_map  = occ_q;
  assign used_cnt = cnt_q;
  assign full     = full_q;
  assign empty    = empty_q;

`ifdef CBB_SLOT_ALLOC_CHK_EN
  logic                 err_q;
  logic [IDX_WIDTH-1:0] err_idx_q;

  // Sticky error: capture only the first free of an unoccupied slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (free_vld && !free_ok && !err_q) begin
      err_q     <= 1'b1;
      err_idx_q <= free_idx;
    end
  end

  assign err_dbl_free = err_q;
  assign err_idx      = err_idx_q;
`endif

endmodule

// File: tb/tb_cbb_slot_alloc.sv
// Self-checking bench for cbb_slot_alloc: directed test-plan steps followed by random
// traffic, all checked against a slot-set model kept in the bench.

module tb_cbb_slot_alloc;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [2:0] alloc_idx;
  logic       free_vld;
  logic [2:0] free_idx;
  logic [7:0] occ_map;
  logic [3:0] used_cnt;
  logic       full;
  logic       empty;
`ifdef CBB_SLOT_ALLOC_CHK_EN
  logic       err_dbl_free;
  logic [2:0] err_idx;
`endif

  int checks;
  int failures;

  // Model: set of occupied slots as an 8-entry bit array.
  bit m_occ [8];
  bit m_err;
  int m_err_idx;

  cbb_slot_alloc u_dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_idx (alloc_idx),
    .free_vld  (free_vld),
    .free_idx  (free_idx),
    .occ_map   (occ_map),
    .used_cnt  (used_cnt),
    .full      (full),
    .empty     (empty)
`ifdef CBB_SLOT_ALLOC_CHK_EN
    ,
    .err_dbl_free (err_dbl_free),
    .err_idx      (err_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_occ[i];
    return n;
  endfunction

  function automatic logic [7:0] model_map();
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = m_occ[i];
    return m;
  endfunction

  // One clock of stimulus: check state/grant against the model, then advance the model.
  task automatic step(input bit rq, input bit fv, input int fi, input bit r);
    int  n;
    bit  exp_gnt;
    int  exp_idx;
    @(negedge clk);
    alloc_req = rq;
    free_vld  = fv;
    free_idx  = fi[2:0];
    rst       = r;
    #1;
    n = model_count();
    check("occ_map", 32'(occ_map), 32'(model_map()));
    check("used_cnt", 32'(used_cnt), 32'(n));
    check("full", 32'(full), 32'(n == 8));
    check("empty", 32'(empty), 32'(n == 0));
`ifdef CBB_SLOT_ALLOC_CHK_EN
    check("err_dbl_free", 32'(err_dbl_free), 32'(m_err));
    check("err_idx", 32'(err_idx), 32'(m_err_idx));
`endif
    exp_gnt = rq && (n < 8);
    exp_idx = 0;
    for (int i = 7; i >= 0; i--) if (!m_occ[i]) exp_idx = i;
    if (n == 8) exp_idx = 0;
    check("alloc_gnt", 32'(alloc_gnt), 32'(exp_gnt));
    check("alloc_idx", 32'(alloc_idx), 32'(exp_idx));
    if (r) begin
      for (int i = 0; i < 8; i++) m_occ[i] = 1'b0;
      m_err     = 1'b0;
      m_err_idx = 0;
    end else begin
      if (fv && !m_occ[fi] && !m_err) begin
        m_err     = 1'b1;
        m_err_idx = fi;
      end
      if (fv && m_occ[fi]) m_occ[fi] = 1'b0;
      if (exp_gnt) m_occ[exp_idx] = 1'b1;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
    free_idx  = '0;
    rst       = 1'b1;
    for (int i = 0; i < 8; i++) m_occ[i] = 1'b0;
    m_err     = 1'b0;
    m_err_idx = 0;
    repeat (2) @(posedge clk);

    // Fill all eight slots, then a ninth request is refused.
    step(1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    // Release slot 3 from full, then it is the next grant.
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Map 0x0F: alloc plus free of slot 1 grants 4, count stays 4.
    step(1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Full map with simultaneous free of 5: no grant, then 5 is granted.
    step(1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 5, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Map 0x01: free of unoccupied slot 6 is ignored (and flagged when checking is built in).
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 6, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Reset wins over a same-cycle alloc and free.
    step(1'b1, 1'b1, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 3));
    end
    step(1'b0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
